// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: one pulse per frame of PERIOD_TICKS timebase ticks.
// Define SLEW_LIMIT_EN to rate-limit width changes to SLEW_STEP per frame.
module servo_pwm_gen #(
   parameter int PERIOD_TICKS = 20000,
   parameter int MIN_PULSE    = 1000,
   parameter int MAX_PULSE    = 2000,
   parameter int CENTER_PULSE = 1500,
   parameter int SLEW_STEP    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] cnt_val,
   input  logic [11:0] cmd_pos,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic        pwm_out,
   output logic        period_start,
   output logic [11:0] cur_width
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [14:0] LAST = 15'(PERIOD_TICKS - 1);
   localparam logic [11:0] MINW = 12'(MIN_PULSE);
   localparam logic [11:0] MAXW = 12'(MAX_PULSE);
   localparam logic [11:0] CENW = 12'(CENTER_PULSE);

   state_t      state_q;
   logic [11:0] cnt_prev_q;
   logic [11:0] pend_q;
   logic        pend_full_q;
   logic        ready_q;
   logic        pwm_q;
   logic        ps_q;
   logic [11:0] width_q;
   logic [11:0] width_d;
   logic [14:0] frame_q;
   logic [14:0] frame_inc;
   logic        tick;
   logic        fs;
   logic        accept;

   function automatic logic [11:0] clamp(input logic [11:0] v);
      if (v < MINW) return MINW;
      else if (v > MAXW) return MAXW;
      else return v;
   endfunction

   assign tick      = (cnt_val != cnt_prev_q);
   assign accept    = cmd_valid && ready_q;
   assign frame_inc = frame_q + 15'd1;
   assign fs        = tick && ((state_q == IDLE) ||
                      ((state_q == LOW) && (frame_q == LAST)));

`ifdef SLEW_LIMIT_EN
   localparam logic [11:0] STEPW = 12'(SLEW_STEP);

   logic [11:0] tgt_q;
   logic [11:0] tgt_d;

   // A freshly consumed command retargets before this frame's step
   always_comb begin
      tgt_d   = pend_full_q ? pend_q : tgt_q;
      width_d = width_q;
      if (tgt_d > width_q)
         width_d = (tgt_d - width_q > STEPW) ? width_q + STEPW : tgt_d;
      else if (tgt_d < width_q)
         width_d = (width_q - tgt_d > STEPW) ? width_q - STEPW : tgt_d;
   end

   always_ff @(posedge clk) begin
      if (rst)
         tgt_q <= CENW;
      else if (fs)
         tgt_q <= tgt_d;
   end
`else
   assign width_d = pend_full_q ? pend_q : width_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_prev_q  <= 12'd0;
         pend_q      <= 12'd0;
         pend_full_q <= 1'b0;
         ready_q     <= 1'b1;
         pwm_q       <= 1'b0;
         ps_q        <= 1'b0;
         width_q     <= CENW;
         frame_q     <= 15'd0;
      end else begin
         cnt_prev_q <= cnt_val;
         ps_q       <= 1'b0;
         // FS frees the slot before a same-edge accept refills it
         if (accept) begin
            pend_q      <= clamp(cmd_pos);
            pend_full_q <= 1'b1;
         end else if (fs) begin
            pend_full_q <= 1'b0;
         end
         ready_q <= !(accept || (pend_full_q && !fs));
         if (fs) begin
            frame_q <= 15'd0;
            ps_q    <= 1'b1;
            pwm_q   <= 1'b1;
            state_q <= HIGH;
            width_q <= width_d;
         end else if (tick) begin
            unique case (state_q)
               HIGH: begin
                  frame_q <= frame_inc;
                  if (frame_inc == {3'b000, width_q}) begin
                     pwm_q   <= 1'b0;
                     state_q <= LOW;
                  end
               end
               LOW:     frame_q <= frame_inc;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      assert (MIN_PULSE >= 1 && MIN_PULSE <= CENTER_PULSE &&
              CENTER_PULSE <= MAX_PULSE && MAX_PULSE < PERIOD_TICKS &&
              PERIOD_TICKS <= 32768 && SLEW_STEP >= 1)
         else $error("servo_pwm_gen: illegal parameter set");
   end

   assign cmd_ready    = ready_q;
   assign pwm_out      = pwm_q;
   assign period_start = ps_q;
   assign cur_width    = width_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Randomized bench for servo_pwm_gen against a frame-position model.
// Scaled parameters keep whole frames within a few hundred cycles.
module tb_servo_pwm_gen;

   localparam int PER  = 100;
   localparam int MINP = 10;
   localparam int MAXP = 40;
   localparam int CEN  = 25;
   localparam int SLEW = 4;
`ifdef SLEW_LIMIT_EN
   localparam int STEP = SLEW;
`else
   localparam int STEP = 4096;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] cnt_val = 12'd4090;
   logic [11:0] cmd_pos = 12'd0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        pwm_out;
   logic        period_start;
   logic [11:0] cur_width;

   int tests = 0;
   int fails = 0;

   // model: position within frame (-1 = idle), width in force, slot, target
   int          m_pos = -1;
   int          m_width = CEN;
   int          m_tgt = CEN;
   int          m_pend = 0;
   bit          m_full = 1'b0;
   bit          m_ready = 1'b1;
   bit          m_ps = 1'b0;
   bit          m_tick = 1'b0;
   logic [11:0] m_prev = 12'd0;
   int          gap = 0;

   always #5 clk = ~clk;

   servo_pwm_gen #(
      .PERIOD_TICKS(PER),
      .MIN_PULSE(MINP),
      .MAX_PULSE(MAXP),
      .CENTER_PULSE(CEN),
      .SLEW_STEP(SLEW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cnt_val(cnt_val),
      .cmd_pos(cmd_pos),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .pwm_out(pwm_out),
      .period_start(period_start),
      .cur_width(cur_width)
   );

   wire [14:0] got = {pwm_out, period_start, cmd_ready, cur_width};

   function automatic int clampf(input int v);
      if (v < MINP) return MINP;
      if (v > MAXP) return MAXP;
      return v;
   endfunction

   function automatic int toward(input int from, input int to);
      if (to > from) return (to - from > STEP) ? from + STEP : to;
      if (to < from) return (from - to > STEP) ? from - STEP : to;
      return from;
   endfunction

   function automatic logic [14:0] expv();
      logic pw;
      pw = (m_pos >= 0) && (m_pos < m_width);
      return {pw, m_ps, m_ready, 12'(m_width)};
   endfunction

   function automatic bit fs_next();
      return !rst && (cnt_val != m_prev) && (m_pos < 0 || m_pos == PER - 1);
   endfunction

   task automatic prep();
      if (gap == 0) begin
         if ($urandom_range(0, 7) == 0)
            cnt_val = cnt_val + 12'($urandom_range(2, 4095));
         else
            cnt_val = cnt_val + 12'd1;
         gap = $urandom_range(0, 2);
      end else begin
         gap--;
      end
   endtask

   task automatic tick_clk();
      bit tk;
      bit acc;
      bit fs;
      @(posedge clk);
      tk = (cnt_val != m_prev);
      acc = cmd_valid && m_ready;
      m_ps = 1'b0;
      m_tick = 1'b0;
      if (rst) begin
         m_prev = 12'd0;
         m_pos = -1;
         m_width = CEN;
         m_tgt = CEN;
         m_full = 1'b0;
         m_ready = 1'b1;
      end else begin
         m_prev = cnt_val;
         m_tick = tk;
         fs = tk && (m_pos < 0 || m_pos == PER - 1);
         m_ps = fs;
         if (fs) begin
            if (m_full) begin
               m_tgt = m_pend;
               m_full = 1'b0;
            end
            m_width = toward(m_width, m_tgt);
            m_pos = 0;
         end else if (tk && m_pos >= 0) begin
            m_pos++;
         end
         if (acc) begin
            m_pend = clampf(int'(cmd_pos));
            m_full = 1'b1;
         end
         m_ready = !m_full;
      end
      #1;
   endtask

   task automatic step();
      prep();
      tick_clk();
   endtask

   task automatic send(input int v);
      cmd_valid = 1'b1;
      cmd_pos = 12'(v);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_pos(input int p, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (m_pos == p) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         step();
         if (m_ps) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_fs_next(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         prep();
         if (fs_next()) begin
            ok = 1'b1;
            break;
         end
         tick_clk();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      tick_clk();
      tests++;
      if (got !== {1'b0, 1'b0, 1'b1, 12'(CEN)}) begin
         fails++;
         $display("FAIL reset_state got=%h want=%h", got, {3'b001, 12'(CEN)});
      end
      tests++;
      if (got !== expv()) begin
         fails++;
         $display("FAIL reset_model got=%h want=%h", got, expv());
      end
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      int hi;
      int tk;
      int frames;
      hi = 0;
      tk = 0;
      frames = 0;
      repeat (800) begin
         step();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL free_run t=%0t got=%h want=%h", $time, got, expv());
         end
         if (period_start) begin
            if (frames > 0) begin
               tests++;
               if (hi != CEN || tk != PER) begin
                  fails++;
                  $display("FAIL frame_shape hi=%0d ticks=%0d want hi=%0d ticks=%0d",
                           hi, tk, CEN, PER);
               end
            end
            frames++;
            hi = 0;
            tk = 0;
         end
         if (m_tick) begin
            tk++;
            if (pwm_out) hi++;
         end
      end
      tests++;
      if (frames < 3) begin
         fails++;
         $display("FAIL frame_count got=%0d want>=3", frames);
      end
   endtask

   task automatic test_cmd();
      bit ok;
      int w1;
      wait_pos(50, ok);
      send(35);
      tests++;
      if (!ok || cmd_ready !== 1'b0 || cur_width !== 12'(CEN)) begin
         fails++;
         $display("FAIL cmd_accept ok=%0b rdy=%b w=%0d want rdy=0 w=%0d",
                  ok, cmd_ready, cur_width, CEN);
      end
      w1 = toward(CEN, 35);
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'(w1) || cmd_ready !== 1'b1 || period_start !== 1'b1) begin
         fails++;
         $display("FAIL cmd_apply ok=%0b w=%0d rdy=%b ps=%b want w=%0d rdy=1 ps=1",
                  ok, cur_width, cmd_ready, period_start, w1);
      end
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'(toward(w1, 35)) || got !== expv()) begin
         fails++;
         $display("FAIL cmd_hold w=%0d want=%0d", cur_width, toward(w1, 35));
      end
   endtask

   task automatic test_clamp();
      bit ok;
      int we;
      wait_pos(50, ok);
      send(3);
      we = toward(m_width, MINP);
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'(we)) begin
         fails++;
         $display("FAIL clamp_low w=%0d want=%0d", cur_width, we);
      end
      wait_pos(50, ok);
      send(3000);
      we = toward(m_width, MAXP);
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'(we)) begin
         fails++;
         $display("FAIL clamp_high w=%0d want=%0d", cur_width, we);
      end
   endtask

   task automatic test_collision();
      bit ok;
      int e1;
      int e2;
      int e3;
      wait_pos(50, ok);
      send(30);
      e1 = toward(m_width, 30);
      wait_fs_next(ok);
      cmd_valid = 1'b1;
      cmd_pos = 12'd20;
      tick_clk();
      tests++;
      if (!ok || period_start !== 1'b1 || cur_width !== 12'(e1) || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL coll_full ps=%b w=%0d rdy=%b want ps=1 w=%0d rdy=1",
                  period_start, cur_width, cmd_ready, e1);
      end
      step();
      cmd_valid = 1'b0;
      tests++;
      if (cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL coll_stall_accept rdy=%b want=0", cmd_ready);
      end
      e2 = toward(e1, 20);
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'(e2)) begin
         fails++;
         $display("FAIL coll_next w=%0d want=%0d", cur_width, e2);
      end
      wait_fs_next(ok);
      cmd_valid = 1'b1;
      cmd_pos = 12'd12;
      tick_clk();
      cmd_valid = 1'b0;
      e3 = toward(e2, 20);
      tests++;
      if (!ok || period_start !== 1'b1 || cur_width !== 12'(e3) || cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL coll_empty ps=%b w=%0d rdy=%b want ps=1 w=%0d rdy=0",
                  period_start, cur_width, cmd_ready, e3);
      end
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'(toward(e3, 12))) begin
         fails++;
         $display("FAIL coll_empty_next w=%0d want=%0d", cur_width, toward(e3, 12));
      end
   endtask

   task automatic test_rst_mid();
      bit ok;
      wait_fs(ok);
      send(33);
      wait_pos(5, ok);
      tests++;
      if (!ok || pwm_out !== 1'b1 || cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL rst_pre pwm=%b rdy=%b want pwm=1 rdy=0", pwm_out, cmd_ready);
      end
      rst = 1'b1;
      tick_clk();
      rst = 1'b0;
      tests++;
      if (got !== {1'b0, 1'b0, 1'b1, 12'(CEN)}) begin
         fails++;
         $display("FAIL rst_mid got=%h want=%h", got, {3'b001, 12'(CEN)});
      end
      repeat (2) begin
         wait_fs(ok);
         tests++;
         if (!ok || cur_width !== 12'(CEN) || got !== expv()) begin
            fails++;
            $display("FAIL rst_drop w=%0d want=%0d", cur_width, CEN);
         end
      end
   endtask

   task automatic test_random();
      repeat (3000) begin
         cmd_valid = ($urandom_range(0, 5) == 0);
         cmd_pos = ($urandom_range(0, 3) == 0) ? 12'($urandom) :
                   12'($urandom_range(0, 60));
         rst = ($urandom_range(0, 1499) == 0);
         step();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL random t=%0t got=%h want=%h", $time, got, expv());
         end
      end
      rst = 1'b0;
      cmd_valid = 1'b0;
   endtask

`ifdef SLEW_LIMIT_EN
   task automatic test_slew();
      bit ok;
      rst = 1'b1;
      tick_clk();
      rst = 1'b0;
      wait_fs(ok);
      send(31);
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'd29) begin
         fails++;
         $display("FAIL slew_1 w=%0d want=29", cur_width);
      end
      wait_fs(ok);
      tests++;
      if (!ok || cur_width !== 12'd31) begin
         fails++;
         $display("FAIL slew_2 w=%0d want=31", cur_width);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_free_run();
      test_cmd();
      test_clamp();
      test_collision();
      test_rst_mid();
      test_random();
`ifdef SLEW_LIMIT_EN
      test_slew();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
